// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, op encodings and write-value helper shared by the CSR unit
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;
  localparam logic [4:0] ECAUSE_ILLEGAL = 5'd2;
  function automatic logic [31:0] csr_wval(input logic [1:0] op, input logic [31:0] old, input logic [31:0] v);
    return op == OP_RW ? v : op == OP_RS ? (old | v) : (old & ~v);
  endfunction
endpackage

// File: rtl/csr_counter.sv
// csr_counter: wrapping W-bit counter with per-half software write that overrides the increment
module csr_counter #(
  parameter int W  = 64,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] inc,
  input  logic          wr_lo,
  input  logic          wr_hi,
  input  logic [31:0]   wdata,
  output logic [W-1:0]  cnt
);
  logic [W-1:0] sum;
  assign sum = cnt + W'(inc);
  // a written half takes wdata; a low write freezes the high half so no carry leaks in
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= {wr_hi ? wdata[W-33:0] : wr_lo ? cnt[W-1:32] : sum[W-1:32], wr_lo ? wdata : sum[31:0]};
endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with trap/MRET tracking and cycle/instret/hpm counters
module csr_unit
  import csr_pkg::*;
#(
  parameter int          ROBID_W    = 7,
  parameter int          RD_W       = 6,
  parameter int          CNT_W      = 64,
  parameter int          NUM_HPM    = 4,
  parameter int          RET_W      = 2,
  parameter logic [31:0] RESET_TVEC = 32'h0,
  localparam int         HW         = NUM_HPM > 0 ? NUM_HPM : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rename_csr_write,
  input  logic [4:0]         rename_op,
  input  logic [ROBID_W-1:0] rename_robid,
  input  logic [RD_W-1:0]    rename_rd,
  input  logic [31:0]        rename_op1,
  input  logic [31:0]        rename_op2,
  output logic               csr_valid,
  output logic               csr_error,
  output logic [4:0]         csr_ecause,
  output logic [ROBID_W-1:0] csr_robid,
  output logic [RD_W-1:0]    csr_rd,
  output logic [31:0]        csr_result,
  input  logic               rob_flush,
  input  logic               rob_csr_valid,
  input  logic               rob_csr_mret,
  input  logic [29:0]        rob_csr_epc,
  input  logic [4:0]         rob_csr_ecause,
  input  logic [31:0]        rob_csr_tval,
  input  logic [RET_W-1:0]   rob_retire_cnt,
  input  logic [HW-1:0]      hpm_event,
  output logic [29:0]        csr_tvec,
  output logic [29:0]        csr_epc
);
  localparam int NC = 2 + NUM_HPM;
  logic [11:0] addr;
  logic [1:0] op;
  logic mie_q, mpie_q;
  logic [29:0] mtvec_q, mepc_q;
  logic [31:0] mscratch_q, mcause_q, mtval_q;
  logic [CNT_W-1:0] cnt [NC];
  logic [NC-1:0] wr_lo, wr_hi;
  logic [31:0] rdata, wval;
  logic impl, is_cnt, chi, valid_op, wr_eff, illegal, accept, do_write;
  logic [4:0] cidx;
  logic [63:0] cx;
  logic unused_bits;
  assign addr = rename_op2[11:0];
  assign op = rename_op[1:0];
  assign unused_bits = ^{rename_op2[31:12], hpm_event};
  // read mux: decode address into old value and implemented flag
  always_comb begin
    impl = 1'b1;
    rdata = '0;
    is_cnt = 1'b0;
    chi = addr[7];
    cidx = addr[4:0] == 5'd0 ? 5'd0 : addr[4:0] - 5'd1;
    cx = '0;
    for (int k = 0; k < NC; k++) if (cidx == 5'(k)) cx = 64'(cnt[k]);
    case (addr)
      CSR_MSTATUS: rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
      CSR_MISA, CSR_MIE, CSR_MIP, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: rdata = '0;
      CSR_MTVEC: rdata = {mtvec_q, 2'b00};
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC: rdata = {mepc_q, 2'b00};
      CSR_MCAUSE: rdata = mcause_q;
      CSR_MTVAL: rdata = mtval_q;
      default: begin
        is_cnt = (addr[11:8] == 4'hB || addr[11:8] == 4'hC) && addr[6:5] == 2'b00 &&
                 (addr[4:0] == 5'd0 || addr[4:0] == 5'd2 ||
                  (addr[4:0] >= 5'd3 && {27'b0, addr[4:0]} < 32'(3 + NUM_HPM)));
        impl = is_cnt;
        rdata = is_cnt ? (chi ? cx[63:32] : cx[31:0]) : '0;
      end
    endcase
  end
  assign wval = csr_wval(op, rdata, rename_op1);
  assign valid_op = rename_op[4:2] == 3'b000 && op != 2'b00;
  assign wr_eff = op == OP_RW || rename_op1 != '0;
  assign illegal = !impl || !valid_op || (wr_eff && addr[11:10] == 2'b11);
  assign accept = rename_csr_write && !rob_flush && !rob_csr_valid && !rob_csr_mret;
  assign do_write = accept && !illegal && wr_eff;
  for (genvar i = 0; i < NC; i++) begin : g_wr
    assign wr_lo[i] = do_write && is_cnt && cidx == 5'(i) && !chi;
    assign wr_hi[i] = do_write && is_cnt && cidx == 5'(i) && chi;
  end
  csr_counter #(.W(CNT_W), .IW(RET_W)) u_mcycle (
    .clk(clk), .rst(rst), .inc(RET_W'(1)), .wr_lo(wr_lo[0]), .wr_hi(wr_hi[0]), .wdata(wval), .cnt(cnt[0])
  );
  csr_counter #(.W(CNT_W), .IW(RET_W)) u_minstret (
    .clk(clk), .rst(rst), .inc(rob_retire_cnt), .wr_lo(wr_lo[1]), .wr_hi(wr_hi[1]), .wdata(wval), .cnt(cnt[1])
  );
  for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
    csr_counter #(.W(CNT_W), .IW(RET_W)) u_hpm (
      .clk(clk), .rst(rst), .inc(RET_W'(hpm_event[i])), .wr_lo(wr_lo[2+i]), .wr_hi(wr_hi[2+i]),
      .wdata(wval), .cnt(cnt[2+i])
    );
  end
  // architectural CSRs: trap beats MRET, both beat software writes
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mie_q <= 1'b0;
      mpie_q <= 1'b0;
      mtvec_q <= RESET_TVEC[31:2];
      mepc_q <= '0;
      mscratch_q <= '0;
      mcause_q <= '0;
      mtval_q <= '0;
    end else if (rob_csr_valid) begin
      mepc_q <= rob_csr_epc;
      mcause_q <= {27'b0, rob_csr_ecause};
      mtval_q <= rob_csr_tval;
      mpie_q <= mie_q;
      mie_q <= 1'b0;
    end else if (rob_csr_mret) begin
      mie_q <= mpie_q;
      mpie_q <= 1'b1;
    end else if (do_write) begin
      if (addr == CSR_MSTATUS) {mpie_q, mie_q} <= {wval[7], wval[3]};
      if (addr == CSR_MTVEC) mtvec_q <= wval[31:2];
      if (addr == CSR_MSCRATCH) mscratch_q <= wval;
      if (addr == CSR_MEPC) mepc_q <= wval[31:2];
      if (addr == CSR_MCAUSE) mcause_q <= wval;
      if (addr == CSR_MTVAL) mtval_q <= wval;
    end
  // writeback result registered for exactly one cycle after an accepted request
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      csr_valid <= 1'b0;
      csr_error <= 1'b0;
      csr_ecause <= '0;
      csr_robid <= '0;
      csr_rd <= '0;
      csr_result <= '0;
    end else begin
      csr_valid <= accept;
      csr_error <= accept && illegal;
      csr_ecause <= accept && illegal ? ECAUSE_ILLEGAL : 5'd0;
      csr_result <= accept && !illegal ? rdata : 32'd0;
      if (accept) {csr_robid, csr_rd} <= {rename_robid, rename_rd};
    end
  assign csr_tvec = mtvec_q;
  assign csr_epc = mepc_q;
endmodule
